// File: rtl/int_ctrl_pkg.sv
// Shared constants and FSM state type for the external interrupt controller.
package int_ctrl_pkg;

    localparam int NUM_SRC_DEF = 8;
    localparam int ID_W        = $clog2(NUM_SRC_DEF);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SIGNAL  = 2'd1,
        SERVICE = 2'd2
    } state_e;

endpackage

// File: rtl/int_prio_enc.sv
// Combinational lowest-index-first priority encoder.
module int_prio_enc #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    output logic [W-1:0] id_o,
    output logic         any_o
);

    // Scan downwards so the lowest set index is the last assignment to stick.
    always_comb begin
        id_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) id_o = W'(i);
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/ext_int_ctrl.sv
// External interrupt controller: pending/enable tracking, claim/complete handshake.
// Build option INT_EDGE_TRIG_EN selects rising-edge triggers; default is level.
module ext_int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter  int NUM_SRC = NUM_SRC_DEF,
    localparam int IDW     = $clog2(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               en_we,
    input  logic [NUM_SRC-1:0] en_wdata,
    output logic [NUM_SRC-1:0] en_mask,
    output logic               ext_int,
    input  logic               claim_req,
    output logic               claim_valid,
    output logic [IDW-1:0]     claim_id,
    output logic               claim_empty,
    input  logic               complete_req,
    input  logic [IDW-1:0]     complete_id
);

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] en_q, en_d;
    logic [IDW-1:0]     svc_q, svc_d;
    logic [IDW-1:0]     cid_q, cid_d;
    logic               cval_q, cval_d;
    logic               cemp_q, cemp_d;
    logic               ext_q;
    logic [NUM_SRC-1:0] trig;
    logic [NUM_SRC-1:0] elig;
    logic [IDW-1:0]     win_id;
    logic               win_any;

`ifdef INT_EDGE_TRIG_EN
    logic [NUM_SRC-1:0] irq_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq_prev_q <= '0;
        else        irq_prev_q <= irq_src;
    end

    assign trig = irq_src & ~irq_prev_q;
`else
    assign trig = irq_src;
`endif

    assign elig = pend_q & en_q;

    int_prio_enc #(.N(NUM_SRC), .W(IDW)) u_enc (
        .req_i (elig),
        .id_o  (win_id),
        .any_o (win_any)
    );

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        svc_d   = svc_q;
        cval_d  = 1'b0;
        cemp_d  = 1'b0;
        cid_d   = '0;
        en_d    = en_we ? en_wdata : en_q;

        case (state_q)
            IDLE:    if (win_any) state_d = SIGNAL;
            SIGNAL:  if (!win_any) state_d = IDLE;
            SERVICE: if (complete_req && (complete_id == svc_q)) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A simultaneous complete takes precedence; the claim is dropped.
        if (claim_req && !complete_req) begin
            cval_d = 1'b1;
            if ((state_q != SERVICE) && win_any) begin
                cid_d   = win_id;
                svc_d   = win_id;
                pend_d  = pend_q & ~(NUM_SRC'(1) << win_id);
                state_d = SERVICE;
            end else begin
                cemp_d = 1'b1;
            end
        end

        // New triggers are merged last so they survive a same-cycle claim.
        pend_d = pend_d | trig;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
            en_q    <= '0;
            svc_q   <= '0;
            cid_q   <= '0;
            cval_q  <= 1'b0;
            cemp_q  <= 1'b0;
            ext_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            en_q    <= en_d;
            svc_q   <= svc_d;
            cid_q   <= cid_d;
            cval_q  <= cval_d;
            cemp_q  <= cemp_d;
            ext_q   <= (state_d == SIGNAL);
        end
    end

    assign en_mask     = en_q;
    assign ext_int     = ext_q;
    assign claim_valid = cval_q;
    assign claim_id    = cid_q;
    assign claim_empty = cemp_q;

endmodule

// File: tb/tb_ext_int_ctrl.sv
// Directed scoreboard bench for ext_int_ctrl; claim responses are checked by a monitor.
module tb_ext_int_ctrl;

    localparam int N  = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  irq_src;
    logic          en_we;
    logic [N-1:0]  en_wdata;
    logic [N-1:0]  en_mask;
    logic          ext_int;
    logic          claim_req;
    logic          claim_valid;
    logic [IW-1:0] claim_id;
    logic          claim_empty;
    logic          complete_req;
    logic [IW-1:0] complete_id;

    int total = 0;
    int bad   = 0;
    logic [3:0] exp_q[$];
    logic [3:0] mon_e;

    always #5 clk = ~clk;

    ext_int_ctrl #(.NUM_SRC(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .irq_src      (irq_src),
        .en_we        (en_we),
        .en_wdata     (en_wdata),
        .en_mask      (en_mask),
        .ext_int      (ext_int),
        .claim_req    (claim_req),
        .claim_valid  (claim_valid),
        .claim_id     (claim_id),
        .claim_empty  (claim_empty),
        .complete_req (complete_req),
        .complete_id  (complete_id)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Monitor: every claim response must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && claim_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_claim: got id=%0d empty=%0b want no response", claim_id, claim_empty);
            end else begin
                mon_e = exp_q.pop_front();
                chk("claim_id", 32'(claim_id), 32'(mon_e[2:0]));
                chk("claim_empty", 32'(claim_empty), 32'(mon_e[3]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wrmask(input logic [N-1:0] m);
        en_we = 1'b1; en_wdata = m;
        step();
        en_we = 1'b0;
    endtask

    task automatic pulse(input logic [N-1:0] m);
        irq_src = m;
        step();
        irq_src = '0;
    endtask

    task automatic claim(input logic [IW-1:0] id, input logic empty);
        exp_q.push_back({empty, id});
        claim_req = 1'b1;
        step();
        claim_req = 1'b0;
    endtask

    task automatic complete(input logic [IW-1:0] id);
        complete_req = 1'b1; complete_id = id;
        step();
        complete_req = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; irq_src = '0; en_we = 1'b0; en_wdata = '0;
        claim_req = 1'b0; complete_req = 1'b0; complete_id = '0;
        step(); step();
        chk("rst_en_mask", 32'(en_mask), 32'h0);
        chk("rst_ext_int", 32'(ext_int), 32'h0);
        chk("rst_claim_valid", 32'(claim_valid), 32'h0);
        rst_n = 1'b1;
        step();

        // Single source, full claim/complete cycle
        wrmask(8'hFF);
        chk("mask_ff", 32'(en_mask), 32'hFF);
        pulse(8'h08);
        chk("ext_before", 32'(ext_int), 32'h0);
        step();
        chk("ext_src3", 32'(ext_int), 32'h1);
        claim(3'd3, 1'b0);
        chk("ext_in_service", 32'(ext_int), 32'h0);
        complete(3'd3);
        step();
        chk("ext_after_cpl3", 32'(ext_int), 32'h0);

        // Two simultaneous sources, lowest index first
        pulse(8'h24);
        step();
        chk("ext_src25", 32'(ext_int), 32'h1);
        claim(3'd2, 1'b0);
        complete(3'd2);
        step();
        chk("ext_src5_left", 32'(ext_int), 32'h1);
        claim(3'd5, 1'b0);
        complete(3'd5);

        // Masked source held pending, released by mask write
        wrmask(8'h00);
        pulse(8'h02);
        step();
        chk("ext_masked_a", 32'(ext_int), 32'h0);
        step();
        chk("ext_masked_b", 32'(ext_int), 32'h0);
        wrmask(8'h02);
        step();
        chk("ext_unmasked", 32'(ext_int), 32'h1);
        claim(3'd1, 1'b0);
        complete(3'd1);

        // Mask removed while signalling drops the request
        wrmask(8'hFF);
        pulse(8'h80);
        step();
        chk("ext_src7", 32'(ext_int), 32'h1);
        wrmask(8'h00);
        chk("ext_mask_lag", 32'(ext_int), 32'h1);
        step();
        chk("ext_mask_drop", 32'(ext_int), 32'h0);
        wrmask(8'hFF);
        step();
        chk("ext_src7_again", 32'(ext_int), 32'h1);
        claim(3'd7, 1'b0);
        complete(3'd7);

        // Mismatched complete ignored; claim during service is empty
        pulse(8'h10);
        step();
        claim(3'd4, 1'b0);
        irq_src = 8'h01; complete_req = 1'b1; complete_id = 3'd6;
        step();
        irq_src = '0; complete_req = 1'b0;
        step();
        chk("ext_still_service", 32'(ext_int), 32'h0);
        claim(3'd0, 1'b1);
        complete(3'd4);
        step();
        chk("ext_src0_after_svc", 32'(ext_int), 32'h1);
        claim(3'd0, 1'b0);
        complete(3'd0);

        // Trigger and claim same source together; then claim+complete together
        pulse(8'h04);
        step();
        irq_src = 8'h04; claim_req = 1'b1; exp_q.push_back({1'b0, 3'd2});
        step();
        irq_src = '0; claim_req = 1'b0;
        complete_req = 1'b1; complete_id = 3'd2; claim_req = 1'b1;
        step();
        complete_req = 1'b0; claim_req = 1'b0;
        step();
        chk("ext_repend_src2", 32'(ext_int), 32'h1);
        claim(3'd2, 1'b0);
        complete(3'd2);

        // Empty claim from idle
        claim(3'd0, 1'b1);
        step();
        chk("ext_idle_empty", 32'(ext_int), 32'h0);

        // Asynchronous reset in the middle of service
        pulse(8'h40);
        step();
        claim(3'd6, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_en_mask", 32'(en_mask), 32'h0);
        chk("arst_ext_int", 32'(ext_int), 32'h0);
        chk("arst_claim_valid", 32'(claim_valid), 32'h0);
        chk("arst_claim_id", 32'(claim_id), 32'h0);
        chk("arst_claim_empty", 32'(claim_empty), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        wrmask(8'hFF);
        claim(3'd0, 1'b1);
        pulse(8'h08);
        step();
        chk("ext_after_arst", 32'(ext_int), 32'h1);
        claim(3'd3, 1'b0);
        complete(3'd3);

        // Source 0 held high for five cycles
        irq_src = 8'h01;
        step(); step();
        claim(3'd0, 1'b0);
        step(); step();
        irq_src = '0;
        complete(3'd0);
        step();
`ifdef INT_EDGE_TRIG_EN
        chk("ext_edge_hold", 32'(ext_int), 32'h0);
        claim(3'd0, 1'b1);
`else
        chk("ext_level_hold", 32'(ext_int), 32'h1);
        claim(3'd0, 1'b0);
        complete(3'd0);
`endif

        step(); step();
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
